seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Runtime-programmable serial bit-pattern detector. It is the parametrised successor to the fixed 4-state Mealy 1010 detector: pattern length and content are loaded at run time, overlap is selectable, and a valid qualifier gates input bits. The block sits on a single-bit serial input stream and flags each completed pattern occurrence. A match is flagged combinationally (Mealy) in the same cycle as the completing bit, and also as a registered pulse one cycle later.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits; must be ≥ 2.
- `CNT_W`, default 16: width of the match counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cfg_load`  in  1  latch `cfg_pattern`, `cfg_len` and `cfg_overlap` this cycle.
- `cfg_pattern`  in  MAX_LEN  pattern bits. `cfg_pattern[len-1]` is the first bit received; `cfg_pattern[0]` is the last.
- `cfg_len`  in  LEN_W  pattern length, where LEN_W = $clog2(MAX_LEN+1). Legal range is 1..MAX_LEN.
- `cfg_overlap`  in  1  1: overlapping matches allowed. 0: history is cleared after each match.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `x_valid`  in  1  `x` carries a stream bit this cycle.
- `x`  in  1  serial data bit.
- `armed`  out  1  a valid configuration is loaded.
- `cfg_err`  out  1  sticky flag: the last load had an illegal `cfg_len`.
- `match`  out  1  combinational Mealy match for the current accepted bit.
- `match_q`  out  1  `match` registered.
- `match_count`  out  CNT_W  saturating count of matches.

## Operation
- **FSM states:** IDLE and ARMED.
  - Reset enters IDLE.
  - In IDLE, `x` is ignored and `match` = 0.
- **cfg_load with legal cfg_len (1..MAX_LEN):**
  - Latch the configuration.
  - Clear history, `fill` and `match_count`.
  - Clear `cfg_err`; next state is ARMED.
- **cfg_load with illegal cfg_len (0 or > MAX_LEN):**
  - Set `cfg_err`; next state is IDLE.
  - Clear history and `fill`.
- **History:** `hist` is MAX_LEN-1 bits, newest bit at bit 0.
  - On each accepted bit (ARMED, `x_valid`, no `cfg_load`), shift `x` in.
  - `fill` counts accepted bits and saturates at `len-1`.
- **Window:** the low `len` bits of {hist, x}.
  - `match` = ARMED & `x_valid` & !`cfg_load` & (`fill` ≥ `len-1`) & (window == `pattern[len-1:0]`).
- **On a match with `overlap` = 0:** `fill` and `hist` clear instead of shifting, so the next match needs `len` fresh bits.
- **On a match with `overlap` = 1:** shift normally.
- **`x_valid` = 0:** no state change and `match` = 0. Gaps do not reset history.
- **Simultaneous `cfg_load` and `x_valid`:**
  - `cfg_load` wins and the bit is dropped.
  - `match` = 0 in that cycle.
- **`len` = 1:** every accepted bit equal to `pattern[0]` matches. Overlap makes no difference.
- **Counter:**
  - Increments on `match` and saturates at 2^CNT_W−1.
  - `cnt_clr` has priority over the increment.
  - A `cfg_load` also clears it.

## Timing
- **Reset values:** state IDLE; `armed` 0; `cfg_err` 0; `match_q` 0; `match_count` 0; `hist` 0; `fill` 0; stored config 0.
- **Latency:**
  - `match` is valid in the same cycle as the completing bit (combinational from `x`, `x_valid` and registers).
  - `match_q` follows one cycle later.
- `armed` rises in the cycle after a legal `cfg_load`. The first bit can be accepted in that same cycle.
- **Reset asserted mid-stream:** everything returns to reset values immediately (asynchronously). The pattern must be reloaded.

## Configuration
- Macro: `SEQDET_MATCH_COUNT_EN`.
  - **Defined:** the counter and the `cnt_clr` logic are present as described above.
  - **Undefined:** `match_count` is tied to 0, `cnt_clr` is ignored and no counter flops are generated. All ports remain in both cases.

## Structure
- Package `seqdet_pkg` holds:
  - the `seqdet_state_t` enum (IDLE, ARMED);
  - the LEN_W computation function;
  - a localparam for the default MAX_LEN.
- One sub-module, `seqdet_window`. It contains:
  - the history shift register;
  - the `fill` counter;
  - the length-masked comparator (produces the raw match).
- The top level holds the FSM, the configuration registers, the overlap clear, `match_q` and the counter.

## Test plan
- **Overlapping 1010:** load `len` = 4, `pattern` = 4'b1010, `overlap` = 1; stream 1,0,1,0,1,0. Expect `match` on bits 4 and 6, and `match_count` = 2.
- **Non-overlapping 1010:** same load with `overlap` = 0, same stream. Expect a match on bit 4 only; `match_count` = 1.
- **Illegal length:** load `cfg_len` = 0 with `MAX_LEN` = 8. Expect `cfg_err` = 1, `armed` = 0, and `match` = 0 for any stream. A following legal load clears `cfg_err`.
- **Load priority:**
  - A `cfg_load` in the same cycle as the completing `x_valid` bit: no match and the bit is dropped.
  - Valid gaps inside a pattern: the match is still flagged on the completing bit.
- **Counter saturation:** `CNT_W` = 2 with the macro defined; `len` = 1, `pattern` = 1; feed five 1s. Expect `match_count` = 3. Then `cnt_clr` together with a matching bit gives 0.
- **Reset mid-pattern:** after 1,0,1 of 1010, pulse `rst` low. Expect `armed` = 0 and all outputs 0; a following 0 bit gives no match.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared types and sizing helpers for the runtime-programmable serial pattern detector.
package seqdet_pkg;

    localparam int DEFAULT_MAX_LEN = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } seqdet_state_t;

    // Width needed to hold a pattern length in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seqdet_if.sv
// Configuration, stream and result signals of the serial pattern detector.
interface seqdet_if
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = 16
);
    localparam int LEN_W = len_w(MAX_LEN);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               x_valid;
    logic               x;
    logic               armed;
    logic               cfg_err;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, x_valid, x,
        input  armed, cfg_err, match, match_q, match_count
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, x_valid, x,
        output armed, cfg_err, match, match_q, match_count
    );

endinterface

// File: rtl/seqdet_window.sv
// History shift register, fill counter and length-masked comparator producing the raw hit.
module seqdet_window #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_x,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [MAX_LEN-1:0] i_pattern,
    output logic               o_hit
);

    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_full;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_m1;

    assign w_full   = {r_hist, i_x};
    assign w_len_m1 = i_len - LEN_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
    end

    assign o_hit = (r_fill >= w_len_m1) && (((w_full ^ i_pattern) & w_mask) == '0);

    // Clear wins over shift so a load or a non-overlapping match restarts the window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_full[MAX_LEN-2:0];
            if (r_fill < w_len_m1) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector top: FSM, config registers, match pulse and counter.
// Optional feature macro: SEQDET_MATCH_COUNT_EN enables the saturating match counter.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst,
    seqdet_if.slave  bus
);

    localparam int LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    seqdet_state_t      r_state;
    seqdet_state_t      w_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_cfg_err;
    logic               r_match_q;
    logic               w_len_ok;
    logic               w_accept;
    logic               w_match;
    logic               w_win_clear;
    logic               w_hit;

    assign w_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A load always wins over a stream bit in the same cycle.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_match     = 1'b0;
        w_win_clear = 1'b0;
        if (bus.cfg_load) begin
            w_next      = w_len_ok ? ARMED : IDLE;
            w_win_clear = 1'b1;
        end else if (r_state == ARMED && bus.x_valid) begin
            w_accept = 1'b1;
            w_match  = w_hit;
            if (w_hit && !r_overlap) begin
                w_win_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
            r_cfg_err <= 1'b0;
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (bus.cfg_load) begin
                r_cfg_err <= !w_len_ok;
                if (w_len_ok) begin
                    r_pattern <= bus.cfg_pattern;
                    r_len     <= bus.cfg_len;
                    r_overlap <= bus.cfg_overlap;
                end
            end
        end
    end

    seqdet_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_win_clear),
        .i_shift   (w_accept),
        .i_x       (bus.x),
        .i_len     (r_len),
        .i_pattern (r_pattern),
        .o_hit     (w_hit)
    );

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (bus.cnt_clr || bus.cfg_load) begin
            r_count <= '0;
        end else if (w_match && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.match_count = r_count;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.cnt_clr;
    assign bus.match_count  = '0;
`endif

    assign bus.armed   = (r_state == ARMED);
    assign bus.cfg_err = r_cfg_err;
    assign bus.match   = w_match;
    assign bus.match_q = r_match_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param with hand-computed expectations.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seqdet_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef SEQDET_MATCH_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        bus.x_valid     = 1'b0;
        tick();
        bus.cfg_load    = 1'b0;
    endtask

    task automatic bit_in(input string tag, input logic b, input logic exp_m);
        bus.x_valid = 1'b1;
        bus.x       = b;
        #1;
        chk({tag, "_match"}, 32'(bus.match), 32'(exp_m));
        tick();
        bus.x_valid = 1'b0;
        chk({tag, "_match_q"}, 32'(bus.match_q), 32'(exp_m));
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cnt_clr     = 1'b0;
        bus.x_valid     = 1'b0;
        bus.x           = 1'b0;
        tick();
        tick();
        chk("rst_armed",   32'(bus.armed),   0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 0);
        chk("rst_match_q", 32'(bus.match_q), 0);
        chk("rst_count",   32'(bus.match_count), 0);
        rst = 1'b1;
        tick();

        // IDLE ignores the stream
        bit_in("idle_b1", 1'b1, 1'b0);
        bit_in("idle_b0", 1'b0, 1'b0);

        // Overlapping 1010
        load(8'b1010, 4'd4, 1'b1);
        chk("ov_armed", 32'(bus.armed), 1);
        bit_in("ov_1", 1'b1, 1'b0);
        bit_in("ov_2", 1'b0, 1'b0);
        bit_in("ov_3", 1'b1, 1'b0);
        bit_in("ov_4", 1'b0, 1'b1);
        bit_in("ov_5", 1'b1, 1'b0);
        bit_in("ov_6", 1'b0, 1'b1);
        chk("ov_count", 32'(bus.match_count), cnt_exp(2));

        // Non-overlapping 1010
        load(8'b1010, 4'd4, 1'b0);
        chk("nov_count_clr", 32'(bus.match_count), 0);
        bit_in("nov_1", 1'b1, 1'b0);
        bit_in("nov_2", 1'b0, 1'b0);
        bit_in("nov_3", 1'b1, 1'b0);
        bit_in("nov_4", 1'b0, 1'b1);
        bit_in("nov_5", 1'b1, 1'b0);
        bit_in("nov_6", 1'b0, 1'b0);
        chk("nov_count", 32'(bus.match_count), cnt_exp(1));

        // Illegal length
        load(8'b1010, 4'd0, 1'b1);
        chk("ill_cfg_err", 32'(bus.cfg_err), 1);
        chk("ill_armed",   32'(bus.armed),   0);
        bit_in("ill_1", 1'b1, 1'b0);
        bit_in("ill_2", 1'b0, 1'b0);
        bit_in("ill_3", 1'b1, 1'b0);
        bit_in("ill_4", 1'b0, 1'b0);
        load(8'b1010, 4'd9, 1'b1);
        chk("ill9_cfg_err", 32'(bus.cfg_err), 1);
        chk("ill9_armed",   32'(bus.armed),   0);
        load(8'b1010, 4'd4, 1'b1);
        chk("legal_cfg_err", 32'(bus.cfg_err), 0);
        chk("legal_armed",   32'(bus.armed),   1);

        // Load collides with the completing bit: bit dropped, history cleared
        bit_in("pri_1", 1'b1, 1'b0);
        bit_in("pri_2", 1'b0, 1'b0);
        bit_in("pri_3", 1'b1, 1'b0);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = 8'b1010;
        bus.cfg_len     = 4'd4;
        bus.cfg_overlap = 1'b1;
        bus.x_valid     = 1'b1;
        bus.x           = 1'b0;
        #1;
        chk("pri_load_match", 32'(bus.match), 0);
        tick();
        bus.cfg_load = 1'b0;
        bus.x_valid  = 1'b0;
        chk("pri_load_match_q", 32'(bus.match_q), 0);

        // Gaps inside the pattern keep history
        bit_in("gap_1", 1'b1, 1'b0);
        tick();
        bit_in("gap_2", 1'b0, 1'b0);
        tick();
        tick();
        bit_in("gap_3", 1'b1, 1'b0);
        bit_in("gap_4", 1'b0, 1'b1);
        chk("gap_count", 32'(bus.match_count), cnt_exp(1));

        // len = 1 and counter saturation
        load(8'b0000_0001, 4'd1, 1'b0);
        bit_in("sat_1", 1'b1, 1'b1);
        bit_in("sat_2", 1'b1, 1'b1);
        bit_in("sat_3", 1'b1, 1'b1);
        bit_in("sat_4", 1'b1, 1'b1);
        bit_in("sat_5", 1'b1, 1'b1);
        chk("sat_count", 32'(bus.match_count), cnt_exp(3));
        bus.cnt_clr = 1'b1;
        bit_in("clr_bit", 1'b1, 1'b1);
        bus.cnt_clr = 1'b0;
        chk("clr_count", 32'(bus.match_count), 0);
        bit_in("len1_zero", 1'b0, 1'b0);
        chk("len1_count", 32'(bus.match_count), 0);

        // Asynchronous reset mid-pattern
        load(8'b1010, 4'd4, 1'b1);
        bit_in("mid_1", 1'b1, 1'b0);
        bit_in("mid_2", 1'b0, 1'b0);
        bit_in("mid_3", 1'b1, 1'b0);
        bus.x_valid = 1'b1;
        bus.x       = 1'b0;
        #1;
        chk("mid_pre_match", 32'(bus.match), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_armed",   32'(bus.armed),   0);
        chk("mid_rst_match",   32'(bus.match),   0);
        chk("mid_rst_match_q", 32'(bus.match_q), 0);
        chk("mid_rst_cfg_err", 32'(bus.cfg_err), 0);
        chk("mid_rst_count",   32'(bus.match_count), 0);
        bus.x_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bit_in("post_rst_0", 1'b0, 1'b0);
        bit_in("post_rst_1", 1'b1, 1'b0);
        bit_in("post_rst_2", 1'b0, 1'b0);
        chk("post_rst_armed", 32'(bus.armed), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
